fp_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one single-precision floating-point multiplier among `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake. It holds the operands stable, pulses the multiplier's start, waits for its done pulse, and returns the product and exception flags to the granted requester as a one-cycle response. It sits between the FP client ports and the multiplier's `start_i`/`done_o` interface.

---
 rtl/fp_mul_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin arbiter/sequencer sharing one FP32 multiplier among NUM_REQ
// requesters. Define FPMUL_ARB_TIMEOUT_EN to build the WAIT-state watchdog.
module fp_mul_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ID_W           = $clog2(NUM_REQ),
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [NUM_REQ*32-1:0] req_a_i,
   input  logic [NUM_REQ*32-1:0] req_b_i,
   output logic [NUM_REQ-1:0]    resp_valid_o,
   output logic [ID_W-1:0]       resp_id_o,
   output logic [31:0]           resp_product_o,
   output logic [4:0]            resp_flags_o,
   output logic                  mul_start_o,
   output logic [31:0]           mul_a_o,
   output logic [31:0]           mul_b_o,
   input  logic                  mul_done_i,
   input  logic                  mul_nan_i,
   input  logic                  mul_inf_i,
   input  logic                  mul_ovf_i,
   input  logic                  mul_unf_i,
   input  logic [31:0]           mul_product_i
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;
   logic [ID_W-1:0] resp_id_q, resp_id_d;
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic [31:0]     prod_q, prod_d;
   logic [4:0]      flags_q, flags_d;

   logic            req_found;
   logic [ID_W-1:0] req_idx;
   logic [ID_W-1:0] cand;
   logic            timeout;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      req_found = 1'b0;
      req_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!req_found && req_valid_i[cand]) begin
            req_found = 1'b1;
            req_idx   = cand;
         end
      end
   end

`ifdef FPMUL_ARB_TIMEOUT_EN
   logic [7:0] wdog_q, wdog_d;

   // Watchdog: cleared on issue, saturating count of WAIT cycles.
   always_comb begin
      wdog_d = wdog_q;
      if (state_q == StIssue) begin
         wdog_d = '0;
      end else if (state_q == StWait && wdog_q != 8'hFF) begin
         wdog_d = wdog_q + 8'd1;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk) begin
      if (rst) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end

   // wdog_d counts the current WAIT cycle, so this fires on the TIMEOUT_CYCLES-th one.
   assign timeout = (state_q == StWait) && (wdog_d >= 8'(TIMEOUT_CYCLES));
`else
   assign timeout = 1'b0;
`endif

   // Next-state, datapath capture and handshake outputs.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_id_d     = gnt_id_q;
      resp_id_d    = resp_id_q;
      a_d          = a_q;
      b_d          = b_q;
      prod_d       = prod_q;
      flags_d      = flags_q;
      req_ready_o  = '0;
      resp_valid_o = '0;
      mul_start_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_found) begin
               req_ready_o[req_idx] = 1'b1;
               a_d      = req_a_i[{req_idx, 5'd0} +: 32];
               b_d      = req_b_i[{req_idx, 5'd0} +: 32];
               gnt_id_d = req_idx;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            mul_start_o = 1'b1;
            state_d     = StWait;
         end
         StWait: begin
            // Done takes priority over a coincident timeout.
            if (mul_done_i) begin
               prod_d    = mul_product_i;
               flags_d   = {1'b0, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
               resp_id_d = gnt_id_q;
               state_d   = StResp;
            end else if (timeout) begin
               prod_d    = '0;
               flags_d   = 5'b10000;
               resp_id_d = gnt_id_q;
               state_d   = StResp;
            end
         end
         StResp: begin
            resp_valid_o[gnt_id_q] = 1'b1;
            rr_ptr_d = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         rr_ptr_q  <= '0;
         gnt_id_q  <= '0;
         resp_id_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         prod_q    <= '0;
         flags_q   <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_id_q  <= gnt_id_d;
         resp_id_q <= resp_id_d;
         a_q       <= a_d;
         b_q       <= b_d;
         prod_q    <= prod_d;
         flags_q   <= flags_d;
      end
   end

   assign mul_a_o        = a_q;
   assign mul_b_o        = b_q;
   assign resp_id_o      = resp_id_q;
   assign resp_product_o = prod_q;
   assign resp_flags_o   = flags_q;

endmodule
